pipelined_kogge_stone_addsub: RTL and testbench
===============================================

// Module: pipelined_kogge_stone_addsub
// PURPOSE
//  Pipelined, parametrised Kogge-Stone adder/subtractor with valid/ready flow control.
//  Next generation of the team's combinational prefix adders: a configurable number of
//  prefix levels per register stage, add/sub mode, and signed-overflow/zero flags.
//  Sits in datapaths that need one result per cycle at high clock rates, with backpressure.
// PARAMETERS
//  DATA_WIDTH        32  operand/result width, >= 2 (any value, not only powers of 2)
//  LEVELS_PER_STAGE  2   prefix levels evaluated between pipeline registers, >= 1
//  (derived) LEVELS = $clog2(DATA_WIDTH); LATENCY = 1 + ceil(LEVELS/LEVELS_PER_STAGE)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           operand beat valid
//  in_ready   out  1           block can accept a beat this cycle
//  a          in   DATA_WIDTH  operand A
//  b          in   DATA_WIDTH  operand B
//  cin        in   1           carry-in (add mode only)
//  op_sub     in   1           0: a+b+cin; 1: a-b (a + ~b + 1; cin ignored)
//  out_valid  out  1           result beat valid
//  out_ready  in   1           downstream accepts the result
//  sum        out  DATA_WIDTH  result
//  cout       out  1           carry-out (sub mode: 1 = no borrow, i.e. a >= b unsigned)
//  ovf        out  1           signed (two's-complement) overflow
//  zero       out  1           sum == 0
// BEHAVIOUR
//  - Reset: every stage valid bit cleared; out_valid, sum, cout, ovf, zero = 0.
//    Reset mid-operation discards all in-flight beats; in_ready = 1 in first cycle after.
//  - Transfer on in_valid & in_ready (input) and out_valid & out_ready (output).
//  - Stage 0 registers b' = op_sub ? ~b : b, c0 = op_sub ? 1 : cin, and bitwise
//    p = a ^ b', g = a & b'. c0 is folded in as bit 0 generate: g0 |= p0 & c0.
//  - Each following register stage evaluates LEVELS_PER_STAGE Kogge-Stone levels
//    (span 1,2,4..): j >= span: g[j] |= p[j] & g[j-span], p[j] &= p[j-span]; else pass-through.
//    Final register stage also holds carries and sum. No ripple carry chain anywhere.
//  - Final stage: c[0]=c0, c[i+1]=G[i]; sum[i]=p_init[i]^c[i]; cout=c[W];
//    ovf = c[W] ^ c[W-1]; zero = ~|sum. p_init carried alongside through each stage.
//  - Latency: result of an accepted beat is presented LATENCY cycles later when never
//    stalled (default W=32: 5 levels, 3 prefix stages, LATENCY=4). Throughput 1/cycle.
//  - Flow control per stage k: stage loads when its valid is 0 or it hands off this cycle;
//    last stage hands off on out_ready. in_ready = stage-0 load condition (combinational
//    from out_ready through the chain). Bubbles collapse: an empty stage fills even when
//    the output is stalled.
//  - While out_valid & ~out_ready: sum/cout/ovf/zero held stable, no beat lost or duplicated.
//  - Beats leave in acceptance order. Stage data registers need no reset; valid bits do.
//  - op_sub and cin are sampled with the operands; mode may change every beat.
// TESTING
//  1. W=32, add a=FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0, zero=1 after 4 cycles.
//  2. W=32, sub a=8000_0000, b=1 -> sum=7FFF_FFFF, cout=1, ovf=1; sub a=0,b=1 -> FFFF_FFFF,
//     cout=0, ovf=0.
//  3. Stream 1000 random beats, out_ready random 50%, in_valid random 70% -> results match
//     reference model in order, none dropped/duplicated, outputs stable while stalled.
//  4. out_ready=0, keep in_valid=1 -> exactly LATENCY beats accepted, then in_ready=0;
//     raise out_ready -> one beat retires per cycle, in_ready returns same cycle.
//  5. Assert rst with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted after.
//  6. Sweep DATA_WIDTH in {2,7,8,33} x LEVELS_PER_STAGE in {1,2,LEVELS} -> exhaustive (W<=8)
//     or 10k random vectors correct; measured latency equals formula.

Source files
------------

// File: rtl/pipelined_kogge_stone_addsub.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Stage 0 forms propagate/generate; later stages run the prefix levels; the last stage registers the result.
module pipelined_kogge_stone_addsub #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned LEVELS_PER_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned LEVELS = $clog2(DATA_WIDTH);
    localparam int unsigned NSP    = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Applies prefix levels lo..hi-1 (span 2^level) to a propagate/generate pair.
    function automatic logic [2*W-1:0] kogge_levels(
        input logic [W-1:0] p_in,
        input logic [W-1:0] g_in,
        input int unsigned  lo,
        input int unsigned  hi
    );
        logic [W-1:0] p_cur, g_cur, p_nxt, g_nxt;
        p_cur = p_in;
        g_cur = g_in;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            if (l >= lo && l < hi) begin
                p_nxt = p_cur;
                g_nxt = g_cur;
                for (int unsigned j = (32'd1 << l); j < W; j++) begin
                    g_nxt[j] = g_cur[j] | (p_cur[j] & g_cur[j - (32'd1 << l)]);
                    p_nxt[j] = p_cur[j] & p_cur[j - (32'd1 << l)];
                end
                p_cur = p_nxt;
                g_cur = g_nxt;
            end
        end
        return {p_cur, g_cur};
    endfunction

    logic [NSP:0]   valid_q, valid_d, load, up_valid, en;
    logic [W-1:0]   p_q  [0:NSP-1];
    logic [W-1:0]   g_q  [0:NSP-1];
    logic [W-1:0]   pi_q [0:NSP-1];
    logic           c0_q [0:NSP-1];
    logic [W-1:0]   p_d  [0:NSP];
    logic [W-1:0]   g_d  [0:NSP];
    logic [W-1:0]   pi_d [0:NSP-1];
    logic           c0_d [0:NSP-1];
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [W-1:0]   b_eff;
    logic           c0;
    logic [W:0]     carry;
    logic [2*W-1:0] pg;

    always_comb begin
        // A stage loads when empty or when its beat moves on; this ripples back to in_ready.
        load      = '0;
        load[NSP] = ~valid_q[NSP] | out_ready;
        for (int unsigned i = 1; i <= NSP; i++) begin
            load[NSP-i] = ~valid_q[NSP-i] | load[NSP-i+1];
        end
        up_valid = {valid_q[NSP-1:0], in_valid};
        en       = load & up_valid;
        valid_d  = (load & up_valid) | (~load & valid_q);
        in_ready = load[0];

        b_eff      = op_sub ? ~b : b;
        c0         = op_sub | cin;
        p_d[0]     = a ^ b_eff;
        g_d[0]     = a & b_eff;
        g_d[0][0]  = g_d[0][0] | (p_d[0][0] & c0);
        pi_d[0]    = a ^ b_eff;
        c0_d[0]    = c0;

        pg = '0;
        for (int unsigned k = 1; k <= NSP; k++) begin
            pg     = kogge_levels(p_q[k-1], g_q[k-1], (k - 1) * LEVELS_PER_STAGE,
                                  k * LEVELS_PER_STAGE);
            p_d[k] = pg[2*W-1:W];
            g_d[k] = pg[W-1:0];
        end
        for (int unsigned k = 1; k < NSP; k++) begin
            pi_d[k] = pi_q[k-1];
            c0_d[k] = c0_q[k-1];
        end

        carry  = {g_d[NSP], c0_q[NSP-1]};
        sum_d  = pi_q[NSP-1] ^ carry[W-1:0];
        cout_d = carry[W];
        ovf_d  = carry[W] ^ carry[W-1];
        zero_d = ~|sum_d;
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NSP; k++) begin
            if (en[k]) begin
                p_q[k]  <= p_d[k];
                g_q[k]  <= g_d[k];
                pi_q[k] <= pi_d[k];
                c0_q[k] <= c0_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (en[NSP]) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = valid_q[NSP];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_kogge_stone_addsub.sv
// Self-checking bench for pipelined_kogge_stone_addsub (W=32, 2 levels per stage, latency 4).
// Expected results are queued at input acceptance and compared in order at output handshake.
module tb_pipelined_kogge_stone_addsub;

    localparam int unsigned W       = 32;
    localparam int unsigned LATENCY = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op_sub;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t cur_exp = '0;
    res_t held = '0;
    bit   hold_pending = 1'b0;
    bit   acc_last = 1'b0;
    bit   pop_last = 1'b0;
    bit   rnd_ready = 1'b0;
    vec_t vecs[12];

    pipelined_kogge_stone_addsub #(
        .DATA_WIDTH       (W),
        .LEVELS_PER_STAGE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W-1:0] yb;
        logic [W:0]   r;
        res_t         o;
        yb     = s ? ~y : y;
        r      = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (s | ci)};
        o.sum  = r[W-1:0];
        o.cout = r[W];
        o.ovf  = (x[W-1] == yb[W-1]) && (r[W-1] != x[W-1]);
        o.zero = (r[W-1:0] == '0);
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then step past the rising edge.
    task automatic tick();
        res_t cur, e;
        @(negedge clk);
        cur      = {sum, cout, ovf, zero};
        acc_last = in_valid && in_ready;
        pop_last = out_valid && out_ready;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!out_valid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b res=%h, expected valid=1 res=%h",
                             out_valid, cur, held);
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = cur;
            if (pop_last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got sum=%h cout=%b ovf=%b zero=%b, expected no beat",
                             sum, cout, ovf, zero);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                                 sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
            end
            if (acc_last) exp_q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input res_t e);
        int guard = 0;
        a        = x;
        b        = y;
        cin      = ci;
        op_sub   = s;
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            tick();
            guard++;
        end while (!acc_last && guard < 1000);
        in_valid = 1'b0;
        if (!acc_last) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b for %0d cycles, expected acceptance", in_ready, guard);
        end
    endtask

    task automatic drain();
        int guard = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         ci, s;
        int           cnt, accepted, retired;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        vecs[5]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[6]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, '{32'h0000_0004, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[10] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[11] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};

        repeat (3) tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'({sum, cout, ovf, zero}), 64'd0);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Unstalled latency from acceptance edge to out_valid.
        x = 32'h0000_00FF;
        y = 32'h0000_0001;
        a = x; b = y; cin = 1'b0; op_sub = 1'b0;
        cur_exp  = model(x, y, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency", 64'(cnt), 64'(LATENCY));
        drain();

        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op_sub, vecs[i].exp);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x  = $urandom;
            y  = (i % 10 == 0) ? x : $urandom;
            ci = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            send(x, y, ci, s, model(x, y, ci, s));
            if ($urandom_range(0, 9) < 3) tick();
        end
        drain();

        // Full backpressure: pipeline absorbs exactly LATENCY beats.
        out_ready = 1'b0;
        accepted  = 0;
        x = $urandom; y = $urandom;
        a = x; b = y; cin = 1'b1; op_sub = 1'b0;
        cur_exp  = model(x, y, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc_last) begin
                accepted++;
                x = $urandom; y = $urandom;
                a = x; b = y; op_sub = accepted[0];
                cur_exp = model(x, y, 1'b1, accepted[0]);
            end
        end
        check("stall_accepted", 64'(accepted), 64'(LATENCY));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("ready_return", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        retired  = 0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            tick();
            if (pop_last) retired++;
        end
        check("retire_per_cycle", 64'(retired), 64'(LATENCY));
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom;
            send(x, y, 1'b0, 1'b1, model(x, y, 1'b0, 1'b1));
        end
        rst = 1'b1;
        tick();
        check("rst_flush_valid", 64'(out_valid), 64'd0);
        rst       = 1'b0;
        check("rst_flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (8) tick();
        check("rst_no_stale", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
